// File: rtl/instr_mem_prog_pkg.sv
// Shared types and constants for the loadable instruction memory.
// Pure declarations: no latency, no flow control.
package instr_mem_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        LOAD = 1'b1
    } state_t;

    localparam logic [31:0] NOP = 32'h0000_0000;

    function automatic int bytes_per_word(input int width);
        return width / 8;
    endfunction

endpackage

// File: rtl/instr_mem_prog_byte_assembler.sv
// Packs a little-endian byte stream into words; word/word_done are combinational with the last byte.
// Accepts one byte per cycle, no backpressure; clear_i drops any partial word.
module byte_assembler
    import instr_mem_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear_i,
    input  logic             byte_vld_i,
    input  logic [7:0]       byte_i,
    output logic [WIDTH-1:0] word_o,
    output logic             word_done_o
);

    localparam int BPW = bytes_per_word(WIDTH);
    localparam int BW  = (BPW > 1) ? $clog2(BPW) : 1;
    localparam logic [BW-1:0] LAST = BW'(BPW - 1);

    logic [BW-1:0]    bcnt_q, bcnt_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;

    always_comb begin
        shreg_d = shreg_q;
        bcnt_d  = bcnt_q;
        if (clear_i) begin
            bcnt_d = '0;
        end else if (byte_vld_i) begin
            for (int i = 0; i < BPW; i++) begin
                if (bcnt_q == BW'(i)) shreg_d[8*i +: 8] = byte_i;
            end
            bcnt_d = (bcnt_q == LAST) ? '0 : bcnt_q + BW'(1);
        end
    end

    // word_o already carries the byte arriving this cycle so the commit can use it directly
    assign word_o      = shreg_d;
    assign word_done_o = byte_vld_i && !clear_i && (bcnt_q == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bcnt_q  <= '0;
            shreg_q <= '0;
        end else begin
            bcnt_q  <= bcnt_d;
            shreg_q <= shreg_d;
        end
    end

endmodule

// File: rtl/instr_mem_prog.sv
// Instruction memory with byte-serial program load and registered fetch (1-cycle latency).
// Fetches accepted only while ready (IDLE); load bytes accepted every cycle in LOAD, no stall.
module instr_mem_prog
    import instr_mem_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int AW    = 8,
    parameter int DEPTH = 2**AW
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [AW-1:0]    A,
    input  logic             rd_en,
    output logic             ready,
    output logic [WIDTH-1:0] RD,
    output logic             rd_valid,
    output logic             addr_err,
    input  logic             load_start,
    input  logic [AW-1:0]    load_base,
    input  logic             load_stop,
    input  logic             load_valid,
    input  logic [7:0]       load_byte,
    output logic             load_err,
    output logic [AW:0]      words_loaded
);

    localparam int MW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0]   DEPTH_W   = (AW+1)'(DEPTH);
    localparam logic [AW:0]   WORDS_MAX = {1'b1, {AW{1'b0}}};
    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

    state_t           state_q, state_d;
    logic [AW-1:0]    waddr_q, waddr_d;
    logic [AW:0]      words_q, words_d;
    logic [WIDTH-1:0] rd_q, rd_d;
    logic             rd_valid_q, addr_err_q, load_err_q;
    logic             ld_active, fetch_acc, fetch_in_range, wr_in_range;
    logic             word_done, mem_we;
    logic [WIDTH-1:0] word;

    logic [WIDTH-1:0] mem [DEPTH];

    byte_assembler #(.WIDTH(WIDTH)) u_asm (
        .clk         (clk),
        .rst_n       (rst_n),
        .clear_i     (load_start),
        .byte_vld_i  (ld_active && load_valid),
        .byte_i      (load_byte),
        .word_o      (word),
        .word_done_o (word_done)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // load_start outranks load_stop, so a combined pulse restarts rather than ends the session
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (load_start) state_d = LOAD;
            LOAD:    if (load_start) state_d = LOAD;
                     else if (load_stop) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        ready     = (state_q == IDLE);
        ld_active = (state_q == LOAD);
    end

    assign fetch_acc      = ready && rd_en;
    assign fetch_in_range = ({1'b0, A} < DEPTH_W);
    assign wr_in_range    = ({1'b0, waddr_q} < DEPTH_W);
    assign mem_we         = word_done && wr_in_range;

    always_comb begin
        rd_d    = rd_q;
        waddr_d = waddr_q;
        words_d = words_q;
        if (fetch_acc) begin
            rd_d = fetch_in_range ? mem[A[MW-1:0]] : WIDTH'(NOP);
        end
        if (load_start) begin
            waddr_d = load_base;
            words_d = '0;
        end else if (word_done) begin
            waddr_d = (waddr_q == LAST_ADDR) ? '0 : waddr_q + AW'(1);
            words_d = (words_q == WORDS_MAX) ? words_q : words_q + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            waddr_q    <= '0;
            words_q    <= '0;
            rd_q       <= '0;
            rd_valid_q <= 1'b0;
            addr_err_q <= 1'b0;
            load_err_q <= 1'b0;
        end else begin
            waddr_q    <= waddr_d;
            words_q    <= words_d;
            rd_q       <= rd_d;
            rd_valid_q <= fetch_acc;
            addr_err_q <= fetch_acc && !fetch_in_range;
            load_err_q <= word_done && !wr_in_range;
        end
    end

    // Contents survive reset so a reset mid-load keeps previously committed words
    always_ff @(posedge clk) begin
        if (mem_we) mem[waddr_q[MW-1:0]] <= word;
    end

    assign RD           = rd_q;
    assign rd_valid     = rd_valid_q;
    assign addr_err     = addr_err_q;
    assign load_err     = load_err_q;
    assign words_loaded = words_q;

endmodule

// File: tb/tb_instr_mem_prog.sv
// Bench for instr_mem_prog with DEPTH=100 so out-of-range fetch and load addresses are reachable.
module tb_instr_mem_prog;

    localparam int W = 32;
    localparam int AW = 8;
    localparam int DEPTH = 100;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [AW-1:0] A = '0;
    logic          rd_en = 1'b0;
    logic          ready;
    logic [W-1:0]  RD;
    logic          rd_valid;
    logic          addr_err;
    logic          load_start = 1'b0;
    logic [AW-1:0] load_base = '0;
    logic          load_stop = 1'b0;
    logic          load_valid = 1'b0;
    logic [7:0]    load_byte = '0;
    logic          load_err;
    logic [AW:0]   words_loaded;

    instr_mem_prog #(.WIDTH(W), .AW(AW), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .A(A), .rd_en(rd_en), .ready(ready), .RD(RD),
        .rd_valid(rd_valid), .addr_err(addr_err), .load_start(load_start),
        .load_base(load_base), .load_stop(load_stop), .load_valid(load_valid),
        .load_byte(load_byte), .load_err(load_err), .words_loaded(words_loaded)
    );

    always #5 clk = ~clk;

    typedef struct { logic [W-1:0] rd; logic err; } exp_t;
    typedef struct { logic [AW-1:0] a; logic [W-1:0] rd; logic err; } vec_t;

    exp_t         sb[$];
    logic [W-1:0] ref_mem [DEPTH];
    int           total = 0;
    int           bad = 0;
    bit           m_idle = 1'b1;
    int           m_waddr = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic exp_t model_fetch(input int a);
        exp_t e;
        e.rd  = (a < DEPTH) ? ref_mem[a] : '0;
        e.err = (a >= DEPTH);
        return e;
    endfunction

    always @(negedge clk) begin
        if (rst_n) begin
            if (rd_valid) begin
                if (sb.size() == 0) begin
                    chk("unexpected_rd_valid", 1, 0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("fetch_RD", RD, e.rd);
                    chk("fetch_addr_err", addr_err, e.err);
                end
            end else if (addr_err) begin
                chk("addr_err_without_valid", 1, 0);
            end
        end
    end

    task automatic fetch(input int a);
        rd_en = 1'b1;
        A = AW'(a);
        if (m_idle) sb.push_back(model_fetch(a));
        step();
        rd_en = 1'b0;
    endtask

    task automatic start(input int base);
        load_start = 1'b1;
        load_base = AW'(base);
        step();
        load_start = 1'b0;
        m_idle = 1'b0;
        m_waddr = base;
    endtask

    task automatic stop();
        load_stop = 1'b1;
        step();
        load_stop = 1'b0;
        m_idle = 1'b1;
    endtask

    task automatic load_word(input logic [W-1:0] w, input bit with_stop);
        for (int i = 0; i < 4; i++) begin
            load_valid = 1'b1;
            load_byte = w[8*i +: 8];
            if (i == 3 && with_stop) load_stop = 1'b1;
            step();
        end
        load_valid = 1'b0;
        load_stop = 1'b0;
        if (m_waddr < DEPTH) begin
            ref_mem[m_waddr] = w;
            chk("load_err_low", load_err, 0);
        end else begin
            chk("load_err_pulse", load_err, 1);
        end
        m_waddr = (m_waddr == DEPTH - 1) ? 0 : (m_waddr + 1) % 256;
        if (with_stop) m_idle = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vt[7];
        vt[0] = '{a: 8'd0,   rd: 32'h0500_0820, err: 1'b0};
        vt[1] = '{a: 8'd5,   rd: 32'hC0DE_0005, err: 1'b0};
        vt[2] = '{a: 8'd15,  rd: 32'hC0DE_000F, err: 1'b0};
        vt[3] = '{a: 8'd19,  rd: 32'hC0DE_0013, err: 1'b0};
        vt[4] = '{a: 8'd6,   rd: 32'hC0DE_0006, err: 1'b0};
        vt[5] = '{a: 8'd122, rd: 32'h0000_0000, err: 1'b1};
        vt[6] = '{a: 8'd3,   rd: 32'hC0DE_0003, err: 1'b0};

        #3;
        chk("rst_RD", RD, 0);
        chk("rst_rd_valid", rd_valid, 0);
        chk("rst_addr_err", addr_err, 0);
        chk("rst_load_err", load_err, 0);
        chk("rst_words_loaded", words_loaded, 0);
        chk("rst_ready", ready, 1);
        #4 rst_n = 1'b1;
        step();

        // First word is addi-style 0x05000820 sent as 20 08 00 05
        start(0);
        chk("ready_in_load", ready, 0);
        load_word(32'h0500_0820, 1'b0);
        for (int i = 1; i < 4; i++) load_word(32'hC0DE_0000 | W'(i), 1'b0);
        chk("words_loaded_4", words_loaded, 4);
        stop();
        chk("ready_after_stop", ready, 1);
        start(4);
        for (int i = 4; i < 20; i++) load_word(32'hC0DE_0000 | W'(i), 1'b0);
        chk("words_loaded_16", words_loaded, 16);
        stop();

        // Back-to-back fetches from the table, one per cycle
        for (int i = 0; i < 7; i++) begin
            rd_en = 1'b1;
            A = vt[i].a;
            sb.push_back('{rd: vt[i].rd, err: vt[i].err});
            step();
        end
        rd_en = 1'b0;
        step();
        step();

        // Write address wraps from DEPTH-1 to 0; out-of-range base drops the word
        start(99);
        load_word(32'hAAAA_0099, 1'b0);
        load_word(32'hBBBB_0000, 1'b0);
        stop();
        fetch(99);
        fetch(0);
        start(120);
        load_word(32'hDEAD_BEEF, 1'b0);
        step();
        chk("load_err_one_cycle", load_err, 0);
        stop();
        fetch(120);

        // Partial word is discarded
        start(10);
        load_valid = 1'b1; load_byte = 8'h11; step();
        load_byte = 8'h22; step();
        load_valid = 1'b0;
        stop();
        chk("partial_words_loaded", words_loaded, 0);
        chk("partial_ready", ready, 1);
        fetch(10);

        // rd_en ignored while loading
        start(30);
        rd_en = 1'b1; A = 8'd5;
        load_word(32'h1111_3030, 1'b0);
        rd_en = 1'b0;
        stop();
        fetch(30);

        // rd_en together with load_start returns pre-load data
        rd_en = 1'b1; A = 8'd31; load_start = 1'b1; load_base = 8'd31;
        sb.push_back(model_fetch(31));
        step();
        rd_en = 1'b0; load_start = 1'b0;
        m_idle = 1'b0; m_waddr = 31;
        chk("start_with_fetch_ready", ready, 0);
        load_word(32'h2222_3131, 1'b1);
        chk("stop_with_last_byte_ready", ready, 1);
        fetch(31);
        fetch(30);

        // load_start wins over a simultaneous load_stop
        start(50);
        load_start = 1'b1; load_stop = 1'b1; load_base = 8'd60;
        step();
        load_start = 1'b0; load_stop = 1'b0;
        m_waddr = 60;
        chk("start_beats_stop_ready", ready, 0);
        load_word(32'h3333_6060, 1'b0);
        chk("restart_words_loaded", words_loaded, 1);
        stop();
        fetch(60);

        // Reset in the middle of a word
        start(40);
        load_word(32'h4444_4040, 1'b0);
        load_valid = 1'b1; load_byte = 8'h99; step();
        load_byte = 8'h88; step();
        load_valid = 1'b0;
        chk("pre_reset_words", words_loaded, 1);
        rst_n = 1'b0;
        #1;
        chk("midrst_RD", RD, 0);
        chk("midrst_words_loaded", words_loaded, 0);
        chk("midrst_ready", ready, 1);
        chk("midrst_rd_valid", rd_valid, 0);
        step();
        rst_n = 1'b1;
        m_idle = 1'b1;
        step();
        fetch(40);
        fetch(5);
        fetch(41);
        step();
        step();

        chk("scoreboard_drained", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
